relu_stream: RTL and testbench

- Multi-lane, pipelined successor to the single-word share-reconstruct-and-ReLU block.
- Each beat carries L lanes of N-bit two's-complement additive shares: garbler share g_input and evaluator share e_input.
- Per lane, the block reconstructs x = g + e mod 2^N, then applies a selectable activation: ReLU, leaky ReLU, clamped ReLU, or passthrough.
- Valid/ready streaming with backpressure, 2-stage pipeline. Sits between share-input staging and the next layer's accumulator.

---
 rtl/relu_stream.sv | 140 ++++++++++++++
 tb/tb_relu_stream.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_stream.sv
// Two-stage streaming share reconstruction and activation: stage 1 adds the
// garbler/evaluator shares per lane, stage 2 applies the selected activation.
module relu_stream #(
    parameter int              N     = 8,
    parameter int              L     = 4,
    parameter int              SHIFT = 3,
    parameter logic [N-1:0]    CLAMP = {1'b0, {(N-1){1'b1}}},
    parameter int              CW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [L*N-1:0]   g_input,
    input  logic [L*N-1:0]   e_input,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [L*N-1:0]   o,
    output logic [CW-1:0]    neg_count
);

    localparam int PW = $clog2(L + 1);
    localparam int SW = ((CW > PW) ? CW : PW) + 1;

    logic             s1_valid_q;
    logic [L*N-1:0]   s1_x_q;
    logic [L*N-1:0]   s1_x_d;
    logic [1:0]       s1_mode_q;
    logic             out_valid_q;
    logic [L*N-1:0]   o_q;
    logic [L*N-1:0]   o_d;
    logic [PW-1:0]    neg_total_q;
    logic [PW-1:0]    neg_total_d;
    logic [CW-1:0]    neg_count_q;
    logic [CW-1:0]    neg_count_d;
    logic [SW-1:0]    neg_sum;
    logic [L-1:0]     neg_vec;

    logic in_fire;
    logic s2_load;
    logic out_fire;

    assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_load;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : g_lane
            logic [N-1:0] x_l;
            logic [N-1:0] leaky_l;
            logic [N-1:0] res_l;

            // N-bit add drops the carry, giving the mod 2^N reconstruction.
            assign s1_x_d[gi*N +: N] = g_input[gi*N +: N] + e_input[gi*N +: N];

            assign x_l         = s1_x_q[gi*N +: N];
            assign neg_vec[gi] = x_l[N-1];
            assign leaky_l     = $signed(x_l) >>> SHIFT;

            always_comb begin
                res_l = x_l;
                case (s1_mode_q)
                    2'd0: res_l = neg_vec[gi] ? '0 : x_l;
                    2'd1: res_l = neg_vec[gi] ? leaky_l : x_l;
                    2'd2: begin
                        if (neg_vec[gi])
                            res_l = '0;
                        else if (x_l > CLAMP)
                            res_l = CLAMP;
                        else
                            res_l = x_l;
                    end
                    default: res_l = x_l;
                endcase
            end

            assign o_d[gi*N +: N] = res_l;
        end
    endgenerate

    always_comb begin
        neg_total_d = '0;
        for (int i = 0; i < L; i++) begin
            neg_total_d = neg_total_d + PW'(neg_vec[i]);
        end
    end

    // Counter saturates at all-ones instead of wrapping.
    assign neg_sum = SW'(neg_count_q) + SW'(neg_total_q);

    always_comb begin
        neg_count_d = neg_count_q;
        if (out_fire) begin
            if (neg_sum > SW'({CW{1'b1}}))
                neg_count_d = {CW{1'b1}};
            else
                neg_count_d = neg_sum[CW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_mode_q   <= '0;
            out_valid_q <= 1'b0;
            o_q         <= '0;
            neg_total_q <= '0;
            neg_count_q <= '0;
        end else begin
            if (in_fire) begin
                s1_x_q    <= s1_x_d;
                s1_mode_q <= mode;
            end

            if (in_fire)
                s1_valid_q <= 1'b1;
            else if (s2_load)
                s1_valid_q <= 1'b0;

            if (s2_load) begin
                o_q         <= o_d;
                neg_total_q <= neg_total_d;
                out_valid_q <= 1'b1;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end

            neg_count_q <= neg_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign o         = o_q;
    assign neg_count = neg_count_q;

endmodule

// File: tb/tb_relu_stream.sv
// Randomized and directed bench for relu_stream; expected results come from a
// FIFO reference model using integer arithmetic on the activation rules.
module tb_relu_stream;

    localparam int TN  = 8;
    localparam int TL  = 2;
    localparam int TS  = 2;
    localparam int TC  = 100;
    localparam int TCW = 4;
    localparam int NCMAX = (1 << TCW) - 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [TL*TN-1:0]  g_input;
    logic [TL*TN-1:0]  e_input;
    logic [1:0]        mode;
    logic              out_valid;
    logic              out_ready;
    logic [TL*TN-1:0]  o;
    logic [TCW-1:0]    neg_count;

    relu_stream #(
        .N(TN), .L(TL), .SHIFT(TS), .CLAMP(8'd100), .CW(TCW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .g_input(g_input), .e_input(e_input), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .neg_count(neg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TL*TN-1:0] g;
        logic [TL*TN-1:0] e;
        logic [1:0]       m;
    } stim_t;

    typedef struct {
        logic [TL*TN-1:0] val;
        int               neg;
        int               acc;
    } exp_t;

    stim_t stim_q[$];
    exp_t  model_q[$];
    int    tests = 0;
    int    fails = 0;
    int    ecount = 0;
    int    nc_model = 0;
    int    n_acc = 0;
    int    n_del = 0;
    logic  fixed_ready = 1'b1;
    logic  rand_ready = 1'b0;
    logic [TL*TN-1:0] last_o = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, ecount);
        end
    endtask

    function automatic logic [TN-1:0] act(input int g, input int e, input int m);
        int x, sx, r;
        x  = (g + e) % 256;
        sx = (x >= 128) ? x - 256 : x;
        case (m)
            0:       r = (sx < 0) ? 0 : x;
            1:       r = (sx < 0) ? (sx - ((1 << TS) - 1)) / (1 << TS) : x;
            2:       r = (sx < 0) ? 0 : ((x > TC) ? TC : x);
            default: r = x;
        endcase
        return r[TN-1:0];
    endfunction

    function automatic exp_t model_beat(input stim_t s, input int acc);
        exp_t r;
        int   gl, el;
        r.val = '0;
        r.neg = 0;
        r.acc = acc;
        for (int i = 0; i < TL; i++) begin
            gl = int'(s.g[i*TN +: TN]);
            el = int'(s.e[i*TN +: TN]);
            r.val[i*TN +: TN] = act(gl, el, int'(s.m));
            if (((gl + el) % 256) >= 128) r.neg++;
        end
        return r;
    endfunction

    task automatic drive();
        if (stim_q.size() > 0) begin
            in_valid = 1'b1;
            g_input  = stim_q[0].g;
            e_input  = stim_q[0].e;
            mode     = stim_q[0].m;
        end else begin
            in_valid = 1'b0;
            g_input  = TL*TN'($urandom);
            e_input  = TL*TN'($urandom);
            mode     = 2'($urandom);
        end
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
    endtask

    task automatic step();
        logic exp_ov, exp_ir;
        #1;
        exp_ov = (model_q.size() > 0) && (model_q[0].acc < ecount);
        exp_ir = (model_q.size() < 2) || out_ready;
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("in_ready", 32'(in_ready), 32'(exp_ir));
        if (exp_ov && out_valid) check("o", 32'(o), 32'(model_q[0].val));
        check("neg_count", 32'(neg_count), 32'(nc_model));
        if (exp_ov && out_ready) begin
            nc_model = nc_model + model_q[0].neg;
            if (nc_model > NCMAX) nc_model = NCMAX;
            last_o = o;
            $display("[TB] edge %0d deliver o=0x%0h neg=%0d", ecount + 1, o, model_q[0].neg);
            void'(model_q.pop_front());
            n_del++;
        end
        if (in_valid && exp_ir) begin
            model_q.push_back(model_beat(stim_q[0], ecount + 1));
            $display("[TB] edge %0d accept g=0x%0h e=0x%0h mode=%0d", ecount + 1, g_input, e_input, mode);
            void'(stim_q.pop_front());
            n_acc++;
        end
        @(posedge clk);
        ecount++;
        #1;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            drive();
            step();
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((stim_q.size() > 0 || model_q.size() > 0) && guard < 300) begin
            drive();
            step();
            guard++;
        end
        if (guard >= 300) check("drain_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [TL*TN-1:0] g, input logic [TL*TN-1:0] e, input logic [1:0] m);
        stim_t s;
        s.g = g;
        s.e = e;
        s.m = m;
        stim_q.push_back(s);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_o", 32'(o), 32'd0);
        check("rst_neg_count", 32'(neg_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        stim_q.delete();
        model_q.delete();
        nc_model = 0;
        in_valid = 1'b0;
        @(posedge clk);
        ecount++;
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int a0;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        g_input = '0;
        e_input = '0;
        mode = '0;
        @(posedge clk);
        ecount++;
        #1;
        do_reset();

        // ReLU: lane0 x=0xF5 (negative), lane1 x=0x32
        push(16'h1005, 16'h22F0, 2'd0);
        drain();
        check("relu_o", 32'(last_o), 32'h3200);
        check("relu_negcnt", 32'(neg_count), 32'd1);

        push(16'h1005, 16'h22F0, 2'd1);
        drain();
        check("leaky_o", 32'(last_o), 32'h32FD);

        // Clamp: lane0 120 -> 100, lane1 0xFF+0x01 wraps to 0
        push(16'hFF64, 16'h0114, 2'd2);
        drain();
        check("clamp_o", 32'(last_o), 32'h0064);

        // Backpressure: only two beats fit while the output is stalled
        fixed_ready = 1'b0;
        a0 = n_acc;
        for (int i = 0; i < 5; i++) push(16'($urandom), 16'($urandom), 2'($urandom));
        run(6);
        check("bp_accepts", 32'(n_acc - a0), 32'd2);
        fixed_ready = 1'b1;
        a0 = n_del;
        run(5);
        check("bp_deliver", 32'(n_del - a0), 32'd5);
        drain();

        // Reset with two beats in flight
        fixed_ready = 1'b0;
        push(16'h8080, 16'h0101, 2'd3);
        push(16'h8080, 16'h0101, 2'd3);
        run(3);
        do_reset();
        fixed_ready = 1'b1;
        push(16'h0102, 16'h0304, 2'd0);
        drain();
        check("post_rst_o", 32'(last_o), 32'h0406);

        // Saturation: two negative lanes per beat
        do_reset();
        for (int i = 0; i < 10; i++) push(16'hF0F0, 16'h0102, 2'd0);
        drain();
        check("sat_negcnt", 32'(neg_count), 32'd15);

        // Random traffic with random backpressure
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0)
                push(16'($urandom), 16'($urandom), 2'($urandom));
            run(1);
        end
        rand_ready = 1'b0;
        fixed_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
